// File: rtl/srlzr_sipo.sv
// Serial-in/parallel-out deserializer with start-bit qualification, stop check and valid/ack output.
// Optional even-parity bit and oPARITY_ERR output when SRLZR_PARITY_EN is defined.
`timescale 1ns/1ps

module srlzr_sipo #(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              srl_in,
    input  logic              iSHIFT,
    output logic [DATA_W-1:0] oDATA_OUT,
    output logic              oDATA_VALID,
    input  logic              iDATA_ACK,
    output logic              oBUSY,
    output logic              oFRAME_ERR,
`ifdef SRLZR_PARITY_EN
    output logic              oPARITY_ERR,
`endif
    output logic              oOVERRUN
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SRLZR_PARITY_EN
    typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START_CHK, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              sync_1;
    logic              sync_2;
    logic              stop_ok;
    logic              frame_good;
`ifdef SRLZR_PARITY_EN
    logic              par_bad;
`endif

    // Pin synchronizer runs every cycle; only the FSM is gated by the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= IDLE_LVL;
            sync_2 <= IDLE_LVL;
        end else begin
            sync_1 <= srl_in;
            sync_2 <= sync_1;
        end
    end

    assign oBUSY   = (state != IDLE);
    assign stop_ok = (sync_2 == IDLE_LVL);
`ifdef SRLZR_PARITY_EN
    assign frame_good = stop_ok && !par_bad;
`else
    assign frame_good = stop_ok;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            oDATA_OUT   <= '0;
            oDATA_VALID <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oOVERRUN    <= 1'b0;
`ifdef SRLZR_PARITY_EN
            oPARITY_ERR <= 1'b0;
            par_bad     <= 1'b0;
`endif
        end else begin
            oFRAME_ERR <= 1'b0;
`ifdef SRLZR_PARITY_EN
            oPARITY_ERR <= 1'b0;
`endif
            if (iDATA_ACK && oDATA_VALID)
                oDATA_VALID <= 1'b0;
            if (iSHIFT) begin
                case (state)
                    IDLE: begin
                        if (sync_2 == ~IDLE_LVL)
                            state <= START_CHK;
                    end
                    START_CHK: begin
                        bit_cnt <= '0;
                        state   <= (sync_2 == ~IDLE_LVL) ? DATA : IDLE;
                    end
                    DATA: begin
                        shift_reg <= {sync_2, shift_reg[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef SRLZR_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SRLZR_PARITY_EN
                    PARITY: begin
                        par_bad <= (^shift_reg) ^ sync_2;
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        state      <= IDLE;
                        oFRAME_ERR <= !stop_ok;
`ifdef SRLZR_PARITY_EN
                        oPARITY_ERR <= par_bad;
`endif
                        // A load overrides the ack clear above, so ack+completion keeps valid high.
                        if (frame_good) begin
                            oDATA_OUT   <= shift_reg;
                            oDATA_VALID <= 1'b1;
                            if (oDATA_VALID && !iDATA_ACK)
                                oOVERRUN <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/srlzr_sipo.md
Name: srlzr_sipo

Overview:
Serial-in/parallel-out deserializer, the receive end of the PISO serializer link. It hunts for a start bit on the serial line and shifts in DATA_W data bits LSB-first, one bit per shift strobe. It then checks the stop bit and presents the word on a valid/ack handshake. It sits between the serial pin domain (same clock) and the parallel consumer logic.

Parameters:
DATA_W, 8, data bits per frame (range 4..32)
IDLE_LVL, 1, idle/stop line level; the start bit is the inverse

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
srl_in  input  1  serial data line
iSHIFT  input  1  bit strobe: srl_in is sampled only on cycles where iSHIFT=1
oDATA_OUT  output  DATA_W  received word, stable while oDATA_VALID=1
oDATA_VALID  output  1  word available, held until acknowledged
iDATA_ACK  input  1  consumer accepts word; effective only when oDATA_VALID=1
oBUSY  output  1  frame reception in progress (state != IDLE)
oFRAME_ERR  output  1  one-cycle pulse: stop bit != IDLE_LVL
oOVERRUN  output  1  sticky: a frame completed while the previous word was unacknowledged

Behaviour:
- Reset (rst=0, async): state=IDLE, bit counter=0, shift register=0, oDATA_OUT=0, oDATA_VALID=0, oBUSY=0, oFRAME_ERR=0, oOVERRUN=0. Deassertion takes effect at the next clk edge. Reset mid-frame discards the partial word.
- Input srl_in passes through a 2-flop synchronizer. Every "sample" below refers to the synchronized value on an iSHIFT=1 cycle. Cycles with iSHIFT=0 hold all state.
- FSM:
  - IDLE: sample == ~IDLE_LVL -> START_CHK, otherwise stay.
  - START_CHK: re-sample. If still ~IDLE_LVL -> DATA with counter=0; else glitch, return to IDLE with no output.
  - DATA: each sample shifts in at the MSB side, so the first received bit ends at bit 0 (LSB-first). Counter increments. After the DATA_W-th sample -> PARITY (macro on) or STOP.
  - PARITY (macro only): sample the parity bit -> STOP.
  - STOP: sample the stop bit -> IDLE. Frame completion occurs on this cycle.
- Consequence of START_CHK: a start bit must last at least 2 strobes. A frame is 1+1+DATA_W(+1)+1 strobes, i.e. the transmitter sends the start bit twice.
- Completion, registered, visible the cycle after the STOP sample:
  - Stop bit == IDLE_LVL: oDATA_OUT <= shift register, oDATA_VALID <= 1.
  - Stop bit wrong: oFRAME_ERR pulses 1 cycle. Word is discarded; oDATA_OUT and oDATA_VALID are unchanged.
  - Good frame while oDATA_VALID=1 and no ack on the same cycle: oOVERRUN <= 1 (sticky until reset). The new word overwrites oDATA_OUT and oDATA_VALID stays 1.
- Handshake: oDATA_VALID clears on the cycle after iDATA_ACK=1. If ack and a good completion occur in the same cycle, the new word loads, oDATA_VALID stays 1, and there is no overrun.
- iDATA_ACK while oDATA_VALID=0 is ignored.
- Latency: oDATA_VALID rises 1 clk after the stop-bit sample edge, plus the 2-cycle synchronizer delay from the pin.
- Reception continues in every state regardless of oDATA_VALID; there is no back-pressure on the line.

Optional Feature:
SRLZR_PARITY_EN
- Defined:
  - One even-parity bit follows the data bits, and the frame grows by 1 strobe.
  - Adds output oPARITY_ERR (1 bit), a one-cycle pulse when the XOR of the data bits and the parity bit != 0.
  - A parity-error frame is discarded like a frame error. If both parity and stop bit are wrong, both pulses assert.
- Undefined: no PARITY state, no oPARITY_ERR port, frame = DATA_W+3 strobes.

Test Plan:
- Reset: hold rst=0 with srl_in toggling and iSHIFT=1 -> all outputs 0; release and idle with srl_in=1 -> oBUSY stays 0.
- Good frame, DATA_W=8, iSHIFT=1 every cycle, stream 0,0,1,0,1,0,0,1,0,1,1 -> oDATA_OUT=8'hA5, oDATA_VALID=1 one cycle after the stop sample; hold until iDATA_ACK, clear the next cycle.
- Glitch and strobe gating: single-strobe 0 then 1 -> no oBUSY beyond START_CHK, no valid. Same good frame with iSHIFT=1 only every 3rd cycle -> 8'hA5.
- Frame error: good data 8'h3C with stop bit 0 -> oFRAME_ERR 1-cycle pulse, oDATA_VALID stays 0.
- Overrun: two back-to-back good frames 8'h11 then 8'h22 with no ack -> oDATA_OUT=8'h22, oOVERRUN=1. Repeat with the ack aligned to the second completion -> oOVERRUN=0.
- With SRLZR_PARITY_EN: 8'hA5 with parity bit 0 -> valid. Parity bit 1 -> oPARITY_ERR pulse, no valid. Reset asserted mid-DATA -> IDLE, next frame received correctly.
